// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared SPI mode decode and slave FSM state encoding
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_SS = 2'd2
  } state_t;

  // Cycles for the synchronisers to flush their reset level after Reset drops
  localparam logic [1:0] SETTLE_CYCLES = 2'd3;

  function automatic logic mode_cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic mode_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// rtl/spi_slave_sync_edge.sv - 2-FF synchroniser with registered rise/fall pulses
module spi_slave_sync_edge #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  // Two-stage synchroniser, then one-flop edge detector; pulse lands 3 cycles after the pin edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= RESET_LEVEL;
      r_sync <= RESET_LEVEL;
      r_prev <= RESET_LEVEL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI target with single-entry transmit hold register
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SPI_MODE   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_sclk,
  input  logic                  i_ss,
  input  logic                  i_mosi,
  output logic                  o_miso,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_load,
  output logic                  o_tx_full,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_rx_abort,
  output logic                  o_tx_underrun,
  output logic                  o_busy
);

  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);
  localparam int   CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic                  w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic                  w_ss_level, w_ss_rise, w_ss_fall;
  logic                  w_cap_edge, w_shf_edge;
  logic                  w_load, w_capture, w_shift, w_word_done, w_abort;
  logic [DATA_WIDTH-1:0] w_tx_word, w_rx_next;

  logic                  r_mosi_meta, r_mosi_sync;
  logic [1:0]            r_settle;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_rx_shift;
  logic [DATA_WIDTH-1:0] r_tx_shift, r_hold, r_rx_data;
  logic                  r_tx_full, r_miso, r_rx_valid, r_rx_abort, r_tx_underrun;

  spi_slave_sync_edge #(.RESET_LEVEL(CPOL)) u_sync_sclk (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_slave_sync_edge #(.RESET_LEVEL(1'b1)) u_sync_ss (
    .i_clk(i_clk), .i_reset(i_reset), .i_pin(i_ss),
    .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  // Leading edge leaves the idle level; CPHA picks which edge captures and which shifts
  assign w_cap_edge = CPHA ? (CPOL ? w_sclk_rise : w_sclk_fall) : (CPOL ? w_sclk_fall : w_sclk_rise);
  assign w_shf_edge = CPHA ? (CPOL ? w_sclk_fall : w_sclk_rise) : (CPOL ? w_sclk_rise : w_sclk_fall);
  assign w_tx_word  = r_tx_full ? r_hold : '0;
  assign w_rx_next  = {r_rx_shift, r_mosi_sync};

  // State register; Reset parks in WAIT_SS so a frame already under way is never joined
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_WAIT_SS;
    else         r_state <= w_state_next;
  end

  // Next state and per-cycle control strobes; SS pulses take priority over SClk pulses
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_shift      = 1'b0;
    w_word_done  = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ss_rise) begin
          w_abort      = (r_bit_cnt != '0);
          w_state_next = ST_IDLE;
        end else if (w_cap_edge) begin
          w_capture = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_word_done = 1'b1;
            w_load      = 1'b1;
          end
        end else if (w_shf_edge) begin
          w_shift = 1'b1;
        end
      end
      ST_WAIT_SS: begin
        if (r_settle == SETTLE_CYCLES && w_ss_level && (w_sclk_level == CPOL))
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_WAIT_SS;
    endcase
  end

  // Datapath: MOSI sync, hold register, receive shifter, transmit shifter and status pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mosi_meta   <= 1'b0;
      r_mosi_sync   <= 1'b0;
      r_settle      <= '0;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_hold        <= '0;
      r_rx_data     <= '0;
      r_tx_full     <= 1'b0;
      r_miso        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_abort    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_mosi_meta   <= i_mosi;
      r_mosi_sync   <= r_mosi_meta;
      r_rx_valid    <= w_word_done;
      r_rx_abort    <= w_abort;
      r_tx_underrun <= w_load & ~r_tx_full;

      if (r_state == ST_WAIT_SS && r_settle != SETTLE_CYCLES)
        r_settle <= r_settle + 2'd1;

      // A load point sees the old TxFull, so a same-cycle TxLoad lands for the following word
      if (w_load && r_tx_full) begin
        r_tx_full <= 1'b0;
      end else if (i_tx_load && !r_tx_full) begin
        r_hold    <= i_tx_data;
        r_tx_full <= 1'b1;
      end

      if (r_state == ST_SHIFT && w_state_next == ST_IDLE) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (w_capture) begin
        r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
        if (w_word_done) begin
          r_rx_data <= w_rx_next;
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      // CPHA=0 frame start drives the MSB at once; at word boundaries the next shift edge presents it
      if (w_state_next != ST_SHIFT) begin
        r_miso <= 1'b0;
      end else if (w_load) begin
        if (!CPHA && r_state == ST_IDLE) begin
          r_miso     <= w_tx_word[DATA_WIDTH-1];
          r_tx_shift <= {w_tx_word[DATA_WIDTH-2:0], 1'b0};
        end else begin
          r_tx_shift <= w_tx_word;
        end
      end else if (w_shift) begin
        r_miso     <= r_tx_shift[DATA_WIDTH-1];
        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_miso        = r_miso;
  assign o_tx_full     = r_tx_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_abort    = r_rx_abort;
  assign o_tx_underrun = r_tx_underrun;
  assign o_busy        = (r_state == ST_SHIFT);

endmodule
